// File: rtl/gsim_sched.sv
// rtl/gsim_sched.sv - round-robin scheduler sharing one Gauss-Seidel solver core among requesters
module gsim_sched #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int NWORD   = 16,
    parameter int TIMEOUT = 4000,
    parameter int RCV_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   b_data,
    output logic [NREQ-1:0]      b_pop,
    output logic                 core_rst,
    output logic                 core_in_en,
    output logic [15:0]          core_b_in,
    input  logic                 core_out_valid,
    input  logic [31:0]          core_x_out,
    output logic                 x_valid,
    output logic [31:0]          x_data,
    output logic [ID_W-1:0]      x_id,
    output logic                 x_last,
    output logic                 err,
    output logic [ID_W-1:0]      err_id,
    output logic                 busy
);

    localparam int CNT_W = $clog2(NWORD + 1);
    localparam int RCV_W = $clog2(RCV_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_RECOVER
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   last_gnt;
    logic [ID_W-1:0]   pick;
    logic              pick_ok;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [15:0]       timer;
    logic [RCV_W-1:0]  rcv_cnt;
    logic [15:0]       slot [NREQ];

    logic load_done;
    logic drain_last;
    logic wait_expired;
    logic rcv_done;

    assign load_done    = (word_cnt == CNT_W'(NWORD - 1));
    assign drain_last   = (out_cnt == CNT_W'(NWORD - 1));
    assign wait_expired = (timer == 16'(TIMEOUT - 1));
    assign rcv_done     = (rcv_cnt == RCV_W'(RCV_CYC - 1));

    // Split the flat b_data bus into one show-ahead word per requester
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot[i] = b_data[16*i +: 16];
        end
    end

    // Round-robin pick: first requesting slot after the last grant, wrapping
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (int'(last_gnt) + i) % NREQ;
            if (!pick_ok && req[idx]) begin
                pick_ok = 1'b1;
                pick    = ID_W'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a valid core word in WAIT takes priority over the watchdog
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pick_ok) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (load_done) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (core_out_valid) state_nx = drain_last ? S_IDLE : S_DRAIN;
                else if (wait_expired) state_nx = S_RECOVER;
            end
            S_DRAIN: begin
                if (!core_out_valid) state_nx = S_RECOVER;
                else if (drain_last) state_nx = S_IDLE;
            end
            S_RECOVER: begin
                if (rcv_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Combinational outputs: pop strobe while loading, core reset during reset and recovery
    always_comb begin
        b_pop    = '0;
        core_rst = reset || (state == S_RECOVER);
        if (!reset && state == S_LOAD) begin
            b_pop = NREQ'(1) << gnt;
        end
    end

    // Datapath: grant bookkeeping, core feed, result routing, watchdog and error report
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= '0;
            last_gnt   <= ID_W'(NREQ - 1);
            word_cnt   <= '0;
            out_cnt    <= '0;
            timer      <= '0;
            rcv_cnt    <= '0;
            core_in_en <= 1'b0;
            core_b_in  <= '0;
            x_valid    <= 1'b0;
            x_data     <= '0;
            x_id       <= '0;
            x_last     <= 1'b0;
            err        <= 1'b0;
            err_id     <= '0;
            busy       <= 1'b0;
        end else begin
            x_valid    <= 1'b0;
            x_last     <= 1'b0;
            err        <= 1'b0;
            core_in_en <= (state == S_LOAD);
            busy       <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        word_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    core_b_in <= slot[gnt];
                    word_cnt  <= word_cnt + CNT_W'(1);
                    if (load_done) begin
                        timer   <= '0;
                        out_cnt <= '0;
                    end
                end
                S_WAIT, S_DRAIN: begin
                    if (state == S_WAIT) timer <= timer + 16'd1;
                    if (core_out_valid) begin
                        x_valid <= 1'b1;
                        x_data  <= core_x_out;
                        x_id    <= gnt;
                        x_last  <= drain_last;
                        out_cnt <= out_cnt + CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    rcv_cnt <= rcv_cnt + RCV_W'(1);
                end
                default: ;
            endcase
            if (state_nx == S_RECOVER && state != S_RECOVER) begin
                err     <= 1'b1;
                err_id  <= gnt;
                rcv_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gsim_sched.sv
// tb/tb_gsim_sched.sv - scoreboard bench for gsim_sched with core and requester models
module tb_gsim_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int NW   = 16;
    localparam int TMO  = 256;
    localparam int RCV  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*16-1:0] b_data;
    logic [NREQ-1:0]    b_pop;
    logic               core_rst, core_in_en, core_out_valid;
    logic [15:0]        core_b_in;
    logic [31:0]        core_x_out, x_data;
    logic               x_valid, x_last, err, busy;
    logic [ID_W-1:0]    x_id, err_id;

    gsim_sched #(.NREQ(NREQ), .ID_W(ID_W), .NWORD(NW), .TIMEOUT(TMO), .RCV_CYC(RCV)) dut (
        .clk(clk), .reset(reset), .req(req), .b_data(b_data), .b_pop(b_pop),
        .core_rst(core_rst), .core_in_en(core_in_en), .core_b_in(core_b_in),
        .core_out_valid(core_out_valid), .core_x_out(core_x_out),
        .x_valid(x_valid), .x_data(x_data), .x_id(x_id), .x_last(x_last),
        .err(err), .err_id(err_id), .busy(busy)
    );

    // single-requester instance
    logic [0:0]  s_req, s_pop, s_xid, s_errid;
    logic [15:0] s_bdata, s_b_in;
    logic        s_core_rst, s_in_en, s_ov, s_xv, s_xl, s_err, s_busy;
    logic [31:0] s_xo, s_xd;

    gsim_sched #(.NREQ(1), .ID_W(1), .NWORD(NW), .TIMEOUT(TMO), .RCV_CYC(RCV)) dut1 (
        .clk(clk), .reset(reset), .req(s_req), .b_data(s_bdata), .b_pop(s_pop),
        .core_rst(s_core_rst), .core_in_en(s_in_en), .core_b_in(s_b_in),
        .core_out_valid(s_ov), .core_x_out(s_xo),
        .x_valid(s_xv), .x_data(s_xd), .x_id(s_xid), .x_last(s_xl),
        .err(s_err), .err_id(s_errid), .busy(s_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [31:0] data; logic [ID_W-1:0] id; logic last; } xexp_t;
    typedef struct { logic [ID_W-1:0] id; bit tmo; } eexp_t;
    xexp_t        xq[$];
    eexp_t        eq[$];
    logic [255:0] bq[$];

    // requester model: per-requester frame of NW words, show-ahead pointer
    logic [15:0] frame [NREQ][NW];
    int          wptr [NREQ];
    int          last_pop_cyc = 0;
    int          exp_gnt = 0;
    int          model_last = NREQ - 1;

    task automatic new_frame(input int i);
        for (int k = 0; k < NW; k++) frame[i][k] = 16'($urandom);
    endtask

    task automatic drive_b();
        for (int i = 0; i < NREQ; i++) b_data[16*i +: 16] = frame[i][wptr[i]];
    endtask

    initial begin
        logic [NREQ-1:0] popped;
        for (int i = 0; i < NREQ; i++) begin
            new_frame(i);
            wptr[i] = 0;
        end
        drive_b();
        forever begin
            @(negedge clk);
            popped = reset ? '0 : b_pop;
            if (popped != '0) check("b_pop_onehot", 64'(b_pop), 64'(1) << exp_gnt);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (popped[i]) begin
                    wptr[i]++;
                    if (wptr[i] == NW) begin
                        wptr[i] = 0;
                        new_frame(i);
                        last_pop_cyc = cyc;
                    end
                end
            end
            drive_b();
        end
    end

    // core model: collect a frame, wait core_lat, answer core_nout words
    int core_lat = 4;
    int core_nout = NW;

    initial begin
        logic [15:0]  rx [NW];
        logic [255:0] got, expf;
        int n;
        core_out_valid = 1'b0;
        core_x_out = '0;
        forever begin
            n = 0;
            while (n < NW) begin
                @(negedge clk);
                if (core_rst) n = 0;
                else if (core_in_en) begin
                    rx[n] = core_b_in;
                    n++;
                end
            end
            for (int k = 0; k < NW; k++) got[16*k +: 16] = rx[k];
            tests++;
            if (bq.size() == 0) begin
                fails++;
                $display("FAIL bframe: got unexpected frame %0h required none", got);
            end else begin
                expf = bq.pop_front();
                if (got !== expf) begin
                    fails++;
                    $display("FAIL bframe: got %0h required %0h", got, expf);
                end
            end
            repeat (core_lat) @(negedge clk);
            for (int k = 0; k < core_nout; k++) begin
                core_out_valid = 1'b1;
                core_x_out = {rx[k], 16'h0100 + 16'(k)};
                @(negedge clk);
            end
            core_out_valid = 1'b0;
        end
    end

    // monitor: pops scoreboard on every result word and error pulse
    initial begin
        int en_run = 0;
        int rst_run = 0;
        xexp_t xe;
        eexp_t ee;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_run = 0;
                rst_run = 0;
            end else begin
                if (core_in_en) en_run++;
                else if (en_run > 0) begin
                    check("in_en_run", 64'(en_run), 64'(NW));
                    en_run = 0;
                end
                if (core_rst) rst_run++;
                else if (rst_run > 0) begin
                    check("core_rst_len", 64'(rst_run), 64'(RCV));
                    rst_run = 0;
                end
                if (x_valid) begin
                    if (xq.size() == 0) check("x_unexpected", 64'(x_valid), 64'(0));
                    else begin
                        xe = xq.pop_front();
                        check("x_data", 64'(x_data), 64'(xe.data));
                        check("x_id", 64'(x_id), 64'(xe.id));
                        check("x_last", 64'(x_last), 64'(xe.last));
                    end
                end
                if (err) begin
                    if (eq.size() == 0) check("err_unexpected", 64'(err), 64'(0));
                    else begin
                        ee = eq.pop_front();
                        check("err_id", 64'(err_id), 64'(ee.id));
                        if (ee.tmo) check("err_timing", 64'(cyc - last_pop_cyc), 64'(TMO));
                    end
                end
            end
        end
    end

    // reference arbitration: next requesting index after the last grant, wrapping
    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (model_last + i) % NREQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic predict(input logic [NREQ-1:0] r, input int nout, input bit tmo);
        int g;
        logic [255:0] p;
        xexp_t xe;
        eexp_t ee;
        g = rr_pick(r);
        model_last = g;
        exp_gnt = g;
        for (int k = 0; k < NW; k++) p[16*k +: 16] = frame[g][k];
        bq.push_back(p);
        for (int k = 0; k < nout; k++) begin
            xe.data = {frame[g][k], 16'h0100 + 16'(k)};
            xe.id = ID_W'(g);
            xe.last = (nout == NW) && (k == NW - 1);
            xq.push_back(xe);
        end
        if (nout < NW) begin
            ee.id = ID_W'(g);
            ee.tmo = tmo;
            eq.push_back(ee);
        end
    endtask

    task automatic wait_busy(input logic v, input int limit, input string name);
        int t = 0;
        while (busy !== v && t < limit) begin
            @(negedge clk);
            #2;
            t++;
        end
        check(name, 64'(busy), 64'(v));
    endtask

    task automatic run_job(input logic [NREQ-1:0] r, input int lat, input int nout, input bit tmo);
        core_lat = lat;
        core_nout = nout;
        predict(r, nout, tmo);
        req = r;
        wait_busy(1'b1, 50, "busy_rise");
        req = '0;
        wait_busy(1'b0, 2000, "busy_fall");
        @(negedge clk);
        #2;
    endtask

    // single-requester models
    int s_cnt = 0;
    int s_xcount = 0;
    int s_jobs = 0;
    int s_err_seen = 0;

    initial begin
        logic sp;
        s_bdata = 16'h5000;
        forever begin
            @(negedge clk);
            sp = s_pop[0] && !reset;
            @(posedge clk);
            #1;
            if (sp) s_cnt++;
            s_bdata = 16'h5000 + 16'(s_cnt);
        end
    end

    initial begin
        logic [15:0] srx [NW];
        int n2;
        s_ov = 1'b0;
        s_xo = '0;
        forever begin
            n2 = 0;
            while (n2 < NW) begin
                @(negedge clk);
                if (s_core_rst) n2 = 0;
                else if (s_in_en) begin
                    srx[n2] = s_b_in;
                    n2++;
                end
            end
            repeat (3) @(negedge clk);
            for (int k = 0; k < NW; k++) begin
                s_ov = 1'b1;
                s_xo = {srx[k], 16'(k)};
                @(negedge clk);
            end
            s_ov = 1'b0;
        end
    end

    initial begin
        int s_run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (s_err) s_err_seen++;
                if (s_in_en) s_run++;
                else if (s_run > 0) begin
                    check("s_in_en_run", 64'(s_run), 64'(NW));
                    s_run = 0;
                end
                if (s_xv) begin
                    check("s_x_id", 64'(s_xid), 64'(0));
                    check("s_x_data", 64'(s_xd), 64'({16'h5000 + 16'(s_xcount), 16'(s_xcount % NW)}));
                    check("s_x_last", 64'(s_xl), 64'((s_xcount % NW) == NW - 1));
                    s_xcount++;
                    if (s_xl) s_jobs++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish required finish by 400000");
        $fatal(1, "bench timeout");
    end

    // stimulus
    initial begin
        int t;
        req = '0;
        s_req = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_b_pop", 64'(b_pop), 0);
        check("rst_core_rst", 64'(core_rst), 1);
        check("rst_core_in_en", 64'(core_in_en), 0);
        check("rst_core_b_in", 64'(core_b_in), 0);
        check("rst_x_valid", 64'(x_valid), 0);
        check("rst_x_data", 64'(x_data), 0);
        check("rst_x_id", 64'(x_id), 0);
        check("rst_x_last", 64'(x_last), 0);
        check("rst_err", 64'(err), 0);
        check("rst_err_id", 64'(err_id), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_s_core_rst", 64'(s_core_rst), 1);
        reset = 1'b0;
        @(negedge clk);
        #2;

        // single job to requester 2, slow core
        for (int k = 0; k < NW; k++) frame[2][k] = 16'(k + 1);
        run_job(4'b0100, 200, NW, 1'b0);

        // core never answers: watchdog abort
        run_job(4'b0010, 10, 0, 1'b1);

        // core stops after 10 words
        run_job(4'b1000, 5, 10, 1'b0);

        // reset in the middle of LOAD
        core_lat = 3;
        core_nout = NW;
        model_last = rr_pick(4'b0001);
        exp_gnt = model_last;
        req = 4'b0001;
        t = 0;
        while (wptr[0] != 7 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("reset_reach_word7", 64'(wptr[0]), 7);
        reset = 1'b1;
        req = 4'b0011;
        @(negedge clk);
        #2;
        check("midrst_b_pop", 64'(b_pop), 0);
        check("midrst_core_in_en", 64'(core_in_en), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_core_rst", 64'(core_rst), 1);
        for (int i = 0; i < NREQ; i++) wptr[i] = 0;
        model_last = NREQ - 1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        run_job(4'b0011, 4, NW, 1'b0);

        // all requesters held, fast core: rotating grants, no interleave
        core_lat = int'($urandom_range(1, 8));
        core_nout = NW;
        for (int j = 0; j < 5; j++) begin
            predict(4'b1111, NW, 1'b0);
            if (j == 0) req = 4'b1111;
            wait_busy(1'b1, 50, "rr_busy_rise");
            if (j == 4) req = '0;
            wait_busy(1'b0, 2000, "rr_busy_fall");
        end
        @(negedge clk);
        #2;

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            int nout;
            nout = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NW - 1)) : NW;
            run_job(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 40)), nout, 1'b0);
        end

        // single-requester instance: three back-to-back jobs
        s_req = 1'b1;
        t = 0;
        while (s_cnt < 2 * NW + 1 && t < 3000) begin
            @(negedge clk);
            #2;
            t++;
        end
        s_req = 1'b0;
        t = 0;
        while ((s_jobs < 3 || s_busy) && t < 3000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("s_jobs", 64'(s_jobs), 3);
        check("s_words", 64'(s_xcount), 64'(3 * NW));
        check("s_err_seen", 64'(s_err_seen), 0);

        repeat (5) @(negedge clk);
        #2;
        check("xq_empty", 64'(xq.size()), 0);
        check("eq_empty", 64'(eq.size()), 0);
        check("bq_empty", 64'(bq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
